apb_master: RTL and testbench

//   APB requester. Turns a simple valid/ready command into one APB transfer per

---
 rtl/apb_master.sv | 129 ++++++++++++
 tb/tb_apb_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one IDLE->SETUP->ACCESS transfer plus a one-cycle response pulse.
// Optional ACCESS timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic                     psel,
    output logic                     penable,
    output logic                     pwrite,
    output logic [ADDRESS_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH-1:0]    prdata,
    input  logic                     pready,
    input  logic                     pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic [ADDRESS_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]      r_pwdata;
    logic                       r_rsp_valid;
    logic                       r_rsp_err;
    logic [DATA_WIDTH-1:0]      r_rsp_rdata;
    logic                       w_accept;
    logic                       w_done;
    logic                       w_timeout;

    // A zero-cycle timeout is meaningless; this empty block only marks the illegal range.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_invalid
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_done    = (r_state == ST_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_acc_cnt;

    // Counts ACCESS cycles already spent; the abort fires on the last allowed one.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == ST_ACCESS) && !pready &&
                       (r_acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_accept ? ST_SETUP : ST_IDLE;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = (pready || w_timeout) ? ST_IDLE : ST_ACCESS;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they change cleanly at the edge.
    always_ff @(posedge pclk) begin
        if (!preset) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_psel      <= (w_state_nxt != ST_IDLE);
            r_penable   <= (w_state_nxt == ST_ACCESS);
            r_rsp_valid <= w_done || w_timeout;
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end
            if (w_done) begin
                r_rsp_err   <= pslverr;
                r_rsp_rdata <= r_pwrite ? '0 : prdata;
            end else if (w_timeout) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: directed transfers push expected responses, a negedge monitor checks them.
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_rsp    = 0;
    int   n_pushed = 0;

    apb_master #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic err, input logic [31:0] rdata, input int at_cyc);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        e.cyc   = at_cyc;
        q.push_back(e);
        n_pushed++;
    endtask

    always @(negedge pclk) begin
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("rsp_err",   {31'b0, rsp_err}, {31'b0, mon_e.err});
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int nwait, input logic [31:0] rdata, input logic err);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        pready    = 1'b0;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = 32'hFFFF_FFFF;
        push_exp(err, wr ? 32'h0 : rdata, cyc + 2 + nwait);
        @(negedge pclk);
        chk("setup_psel",    {31'b0, psel},    32'd1);
        chk("setup_penable", {31'b0, penable}, 32'd0);
        chk("setup_pwrite",  {31'b0, pwrite},  {31'b0, wr});
        chk("setup_paddr",   paddr, addr);
        if (wr) chk("setup_pwdata", pwdata, wdata);
        @(posedge pclk); #1;
        for (int i = 0; i <= nwait; i++) begin
            pready  = (i == nwait);
            prdata  = (i == nwait) ? rdata : 32'h0BAD_0BAD;
            pslverr = (i == nwait) ? err : 1'b1;
            @(negedge pclk);
            chk("access_strobes", {30'b0, psel, penable}, 32'd3);
            chk("access_paddr",   paddr, addr);
            @(posedge pclk); #1;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        @(negedge pclk);
        chk("rsp_cycle_psel",  {31'b0, psel},      32'd0);
        chk("rsp_cycle_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge pclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_psel [6];
        exp_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset with a live command and ready slave: nothing may start.
        preset    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h55;
        cmd_wdata = 32'h1234;
        prdata    = 32'h0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk("reset_psel",      {31'b0, psel},      32'd0);
        chk("reset_penable",   {31'b0, penable},   32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_err",   {31'b0, rsp_err},   32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_paddr",     paddr, 32'h0);
        preset    = 1'b1;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge pclk);
        chk("post_reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_reset_psel",  {31'b0, psel},      32'd0);
        @(posedge pclk); #1;

        do_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, 1'b0);
        do_xfer(1'b0, 32'h24, 32'h0,         3, 32'h1234_5678, 1'b0);
        do_xfer(1'b0, 32'h30, 32'h0,         0, 32'hAAAA_5555, 1'b1);
        do_xfer(1'b0, 32'h34, 32'h0,         1, 32'h0F0F_0F0F, 1'b0);
        do_xfer(1'b1, 32'h38, 32'h8765_4321, 2, 32'h7777_7777, 1'b1);

        // Back-to-back writes with cmd_valid held high.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h100;
        cmd_wdata = 32'h1111_1111;
        pready    = 1'b1;
        prdata    = 32'h0;
        @(posedge pclk); #1;
        push_exp(1'b0, 32'h0, cyc + 2);
        push_exp(1'b0, 32'h0, cyc + 5);
        cmd_addr  = 32'h104;
        cmd_wdata = 32'h2222_2222;
        for (int k = 0; k < 6; k++) begin
            @(negedge pclk);
            chk("b2b_psel", {31'b0, psel}, {31'b0, exp_psel[k]});
            if (k == 0) chk("b2b_paddr_a", paddr, 32'h100);
            if (k == 3) chk("b2b_paddr_b", paddr, 32'h104);
            if (k == 3) chk("b2b_pwdata_b", pwdata, 32'h2222_2222);
            @(posedge pclk); #1;
            if (k == 2) cmd_valid = 1'b0;
        end
        pready = 1'b0;
        chk("hold_paddr",  paddr,  32'h104);
        chk("hold_pwdata", pwdata, 32'h2222_2222);

        // Reset in the middle of ACCESS while the slave is about to complete.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("midrst_access", {30'b0, psel, penable}, 32'd3);
        preset = 1'b0;
        pready = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        pready = 1'b0;
        @(negedge pclk);
        chk("midrst_strobes", {30'b0, psel, penable}, 32'd0);
        chk("midrst_paddr",   paddr, 32'h0);
        repeat (4) @(posedge pclk);
        #1;

        // Slave never becomes ready.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h80;
        pready    = 1'b0;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        push_exp(1'b1, 32'h0, cyc + 17);
        repeat (16) @(posedge pclk);
        @(negedge pclk);
        chk("to_last_access", {30'b0, psel, penable}, 32'd3);
        @(posedge pclk);
        @(negedge pclk);
        chk("to_psel_drop", {30'b0, psel, penable}, 32'd0);
        @(posedge pclk); #1;
`else
        repeat (101) @(posedge pclk);
        @(negedge pclk);
        chk("stuck_access", {30'b0, psel, penable}, 32'd3);
        preset = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b1;
`endif
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("rsp_count",   n_rsp, n_pushed);
        chk("queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
